// File: rtl/wdom_rptr_monitor.sv
// wdom_rptr_monitor
// Write-domain receiver for the async FIFO read-side Gray pointer.
// Synchronizes rptr into wclk, decodes it to binary and derives a registered
// fill level with almost-full, full, sticky overflow and (optionally) a
// high-water mark.
//
// Parameters:
//   ASIZE        FIFO address width; depth = 2**ASIZE, pointers ASIZE+1 bits
//   SYNC_STAGES  rptr synchronizer depth, 2..4
//   AFULL_TH     almost-full threshold in entries, 1..DEPTH
//
// Ports:
//   wclk          write clock
//   wrstn         asynchronous active-low reset
//   rptr          read pointer (Gray, read clock domain)
//   wbin          write pointer (binary, wclk domain)
//   wen           write attempt this cycle
//   ovf_clr       clears woverflow (a simultaneous set wins)
//   hwm_clr       restarts high-water-mark tracking from the current level
//   w_rptr        synchronized Gray read pointer
//   wcount        registered fill level, clamped to DEPTH
//   walmost_full  registered, wcount >= AFULL_TH
//   wfull_reg     registered, wcount == DEPTH
//   woverflow     sticky: rejected write or corrupt (> DEPTH) level seen
//   whwm          maximum wcount since reset / last hwm_clr
//
// Configuration macro WDOM_RPTR_HWM_EN: when defined the high-water-mark
// register is built; otherwise whwm is tied to 0 and hwm_clr is ignored.

module wdom_rptr_monitor #(
    parameter int ASIZE       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_TH    = 12
) (
    input  logic             wclk,
    input  logic             wrstn,
    input  logic [ASIZE:0]   rptr,
    input  logic [ASIZE:0]   wbin,
    input  logic             wen,
    input  logic             ovf_clr,
    input  logic             hwm_clr,
    output logic [ASIZE:0]   w_rptr,
    output logic [ASIZE:0]   wcount,
    output logic             walmost_full,
    output logic             wfull_reg,
    output logic             woverflow,
    output logic [ASIZE:0]   whwm
);

    localparam int             DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_V = DEPTH[ASIZE:0];
    localparam logic [ASIZE:0] AFULL_V = AFULL_TH[ASIZE:0];

    // ------------------------------------------------------------------
    // rptr synchronizer: plain flop chain, no logic between stages
    // ------------------------------------------------------------------
    logic [ASIZE:0] sync_q [SYNC_STAGES];

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= rptr;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign w_rptr = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Gray decode and level
    // ------------------------------------------------------------------
    logic [ASIZE:0] rbin;
    logic [ASIZE:0] lvl;
    logic [ASIZE:0] lvl_c;
    logic           lvl_over;
    logic           full_c;

    // rbin[k] is the XOR of all Gray bits at or above k, which is the
    // MSB-down cascade rbin[k] = rbin[k+1] ^ g[k] written without a chain.
    always_comb begin
        rbin = '0;
        for (int unsigned k = 0; k <= ASIZE; k++) begin
            rbin[k] = ^(w_rptr >> k);
        end
    end

    // Modular subtraction at ASIZE+1 bits makes pointer wrap transparent.
    assign lvl      = wbin - rbin;
    assign lvl_over = (lvl > DEPTH_V);
    assign lvl_c    = lvl_over ? DEPTH_V : lvl;
    assign full_c   = (lvl == DEPTH_V);

    // ------------------------------------------------------------------
    // Registered level, flags and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            wcount       <= '0;
            walmost_full <= 1'b0;
            wfull_reg    <= 1'b0;
            woverflow    <= 1'b0;
        end else begin
            wcount       <= lvl_c;
            walmost_full <= (lvl_c >= AFULL_V);
            wfull_reg    <= (lvl_c == DEPTH_V);
            // set has priority over clear
            if ((wen && full_c) || lvl_over) begin
                woverflow <= 1'b1;
            end else if (ovf_clr) begin
                woverflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // High-water mark
    // ------------------------------------------------------------------
`ifdef WDOM_RPTR_HWM_EN
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            whwm <= '0;
        end else if (hwm_clr) begin
            // restart from the current level rather than 0
            whwm <= lvl_c;
        end else if (lvl_c > whwm) begin
            whwm <= lvl_c;
        end
    end
`else
    logic unused_hwm_clr;
    assign unused_hwm_clr = hwm_clr;
    assign whwm           = '0;
`endif

endmodule

// File: tb/tb_wdom_rptr_monitor.sv
// Directed self-checking bench for wdom_rptr_monitor (ASIZE=4,
// SYNC_STAGES=2, AFULL_TH=12). Expected whwm values follow the build:
// they are the tracked maximum when WDOM_RPTR_HWM_EN is defined, 0 otherwise.

module tb_wdom_rptr_monitor;

    logic       wclk = 1'b0;
    logic       wrstn;
    logic [4:0] rptr;
    logic [4:0] wbin;
    logic       wen;
    logic       ovf_clr;
    logic       hwm_clr;
    logic [4:0] w_rptr;
    logic [4:0] wcount;
    logic       walmost_full;
    logic       wfull_reg;
    logic       woverflow;
    logic [4:0] whwm;

    int errors = 0;
    int checks = 0;

    wdom_rptr_monitor #(
        .ASIZE       (4),
        .SYNC_STAGES (2),
        .AFULL_TH    (12)
    ) dut (
        .wclk         (wclk),
        .wrstn        (wrstn),
        .rptr         (rptr),
        .wbin         (wbin),
        .wen          (wen),
        .ovf_clr      (ovf_clr),
        .hwm_clr      (hwm_clr),
        .w_rptr       (w_rptr),
        .wcount       (wcount),
        .walmost_full (walmost_full),
        .wfull_reg    (wfull_reg),
        .woverflow    (woverflow),
        .whwm         (whwm)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        string      name;
        logic [4:0] rptr;
        logic [4:0] wbin;
        logic       wen;
        logic       ovf_clr;
        int         ncyc;
        logic [4:0] e_wrptr;
        logic [4:0] e_wcount;
        logic       e_af;
        logic       e_full;
        logic       e_ovf;
        logic [4:0] e_hwm;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [4:0] eh(input logic [4:0] v);
`ifdef WDOM_RPTR_HWM_EN
        return v;
`else
        return 5'd0;
`endif
    endfunction

    function automatic vec_t mk(input string n, input logic [4:0] r, input logic [4:0] w,
                                input logic we, input logic oc, input int nc,
                                input logic [4:0] ewr, input logic [4:0] ewc,
                                input logic eaf, input logic efu, input logic eov,
                                input logic [4:0] ehw);
        vec_t v;
        v.name = n; v.rptr = r; v.wbin = w; v.wen = we; v.ovf_clr = oc; v.ncyc = nc;
        v.e_wrptr = ewr; v.e_wcount = ewc; v.e_af = eaf; v.e_full = efu;
        v.e_ovf = eov; v.e_hwm = ehw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string n, input logic [4:0] ewr, input logic [4:0] ewc,
                             input logic eaf, input logic efu, input logic eov,
                             input logic [4:0] ehw);
        chk({n, ".w_rptr"},       32'(w_rptr),       32'(ewr));
        chk({n, ".wcount"},       32'(wcount),       32'(ewc));
        chk({n, ".walmost_full"}, 32'(walmost_full), 32'(eaf));
        chk({n, ".wfull_reg"},    32'(wfull_reg),    32'(efu));
        chk({n, ".woverflow"},    32'(woverflow),    32'(eov));
        chk({n, ".whwm"},         32'(whwm),         32'(ehw));
    endtask

    task automatic edge1;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        // ---------------- reset hold and release ----------------
        wrstn = 1'b0; rptr = 5'b10110; wbin = 5'd9;
        wen = 1'b0; ovf_clr = 1'b0; hwm_clr = 1'b0;
        repeat (3) edge1();
        check_all("rst_hold", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        wrstn = 1'b1;
        edge1();
        edge1();
        chk("rst_sync.w_rptr", 32'(w_rptr), 32'(5'b10110));
        edge1();
        // Gray 10110 -> 27, (9 - 27) mod 32 = 14
        check_all("rst_lvl", 5'b10110, 5'd14, 1'b1, 1'b0, 1'b0, eh(5'd14));

        // ---------------- fill to full ----------------
        rptr = 5'd0; wbin = 5'd0;
        repeat (3) edge1();
        check_all("fill_base", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, eh(5'd14));
        for (int w = 1; w <= 16; w++) begin
            wbin = 5'(w);
            edge1();
            check_all($sformatf("fill_%0d", w), 5'd0, 5'(w), (w >= 12), (w == 16),
                      1'b0, eh(5'(w > 14 ? w : 14)));
        end

        // ---------------- table-driven vectors ----------------
        vecs.push_back(mk("ovf_set",      5'd0, 5'd16, 1, 0, 1, 5'd0, 5'd16, 1, 1, 1, eh(5'd16)));
        vecs.push_back(mk("ovf_set_wins", 5'd0, 5'd16, 1, 1, 1, 5'd0, 5'd16, 1, 1, 1, eh(5'd16)));
        vecs.push_back(mk("ovf_clr",      5'd0, 5'd16, 0, 1, 1, 5'd0, 5'd16, 1, 1, 0, eh(5'd16)));
        vecs.push_back(mk("ovf_hold0",    5'd0, 5'd16, 0, 0, 1, 5'd0, 5'd16, 1, 1, 0, eh(5'd16)));
        vecs.push_back(mk("wrap",         5'b10011, 5'd3, 0, 0, 3, 5'b10011, 5'd6, 0, 0, 0, eh(5'd16)));
        vecs.push_back(mk("wen_notfull",  5'b10011, 5'd3, 1, 0, 1, 5'b10011, 5'd6, 0, 0, 0, eh(5'd16)));
        vecs.push_back(mk("corrupt",      5'd0, 5'd20, 0, 0, 3, 5'd0, 5'd16, 1, 1, 1, eh(5'd16)));
        vecs.push_back(mk("corrupt_clr",  5'd0, 5'd20, 0, 1, 1, 5'd0, 5'd16, 1, 1, 1, eh(5'd16)));
        vecs.push_back(mk("recover_clr",  5'd0, 5'd4,  0, 1, 1, 5'd0, 5'd4,  0, 0, 0, eh(5'd16)));
        vecs.push_back(mk("afull_11",     5'd0, 5'd11, 0, 0, 1, 5'd0, 5'd11, 0, 0, 0, eh(5'd16)));
        vecs.push_back(mk("afull_12",     5'd0, 5'd12, 0, 0, 1, 5'd0, 5'd12, 1, 0, 0, eh(5'd16)));

        foreach (vecs[i]) begin
            rptr = vecs[i].rptr; wbin = vecs[i].wbin;
            wen = vecs[i].wen; ovf_clr = vecs[i].ovf_clr;
            repeat (vecs[i].ncyc) edge1();
            check_all(vecs[i].name, vecs[i].e_wrptr, vecs[i].e_wcount, vecs[i].e_af,
                      vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_hwm);
        end
        wen = 1'b0; ovf_clr = 1'b0;

        // ---------------- high-water-mark clear ----------------
        hwm_clr = 1'b1; wbin = 5'd0;
        edge1();
        check_all("hwm_restart", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, eh(5'd0));
        hwm_clr = 1'b0; wbin = 5'd13;
        edge1();
        check_all("hwm_rise13", 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, eh(5'd13));
        rptr = 5'b01101;   // Gray(9): level drains to 4
        repeat (3) edge1();
        check_all("hwm_drain", 5'b01101, 5'd4, 1'b0, 1'b0, 1'b0, eh(5'd13));
        edge1();
        chk("hwm_hold.whwm", 32'(whwm), 32'(eh(5'd13)));
        hwm_clr = 1'b1;
        edge1();
        chk("hwm_clr.whwm", 32'(whwm), 32'(eh(5'd4)));
        hwm_clr = 1'b0;
        edge1();
        chk("hwm_after.whwm", 32'(whwm), 32'(eh(5'd4)));

        // ---------------- asynchronous reset mid-operation ----------------
        wrstn = 1'b0;
        #2;
        check_all("mid_rst_async", 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        edge1();
        wrstn = 1'b1;
        edge1();
        edge1();
        chk("mid_rst_sync.w_rptr", 32'(w_rptr), 32'(5'b01101));
        edge1();
        check_all("mid_rst_lvl", 5'b01101, 5'd4, 1'b0, 1'b0, 1'b0, eh(5'd13));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wdom_rptr_monitor.md
# wdom_rptr_monitor

Write-domain receiver for the read-side Gray pointer of the async FIFO. Synchronizes the read pointer `rptr` into `wclk`, decodes it to binary and computes the registered fill level. From that level it derives almost-full, a registered full flag, a sticky overflow error and an optional high-water mark. Its `w_rptr` output is the synchronized Gray pointer that the write-side full logic compares against `wptr`.

## Interface
- `ASIZE`, 4: FIFO address width; depth `DEPTH` = 2^ASIZE, pointers are ASIZE+1 bits.
- `SYNC_STAGES`, 2: flop stages in the `rptr` synchronizer; legal range 2..4.
- `AFULL_TH`, 12: almost-full threshold in entries; legal range 1..DEPTH.

Ports:
- `wclk` in 1: write clock.
- `wrstn` in 1: reset, asynchronous, active-low.
- `rptr` in ASIZE+1: read pointer, Gray code, launched from the read clock domain.
- `wbin` in ASIZE+1: write pointer, binary, `wclk` domain.
- `wen` in 1: write attempt this cycle.
- `ovf_clr` in 1: clears `woverflow`.
- `hwm_clr` in 1: restarts high-water-mark tracking.
- `w_rptr` out ASIZE+1: synchronized Gray read pointer.
- `wcount` out ASIZE+1: registered fill level, 0..DEPTH.
- `walmost_full` out 1: registered; 1 when `wcount` >= `AFULL_TH`.
- `wfull_reg` out 1: registered; 1 when `wcount` == DEPTH.
- `woverflow` out 1: sticky error flag.
- `whwm` out ASIZE+1: maximum `wcount` seen since reset or the last `hwm_clr`.

## Operation
- **Synchronizer.** `rptr` passes through `SYNC_STAGES` flops clocked by `wclk`. The last stage drives `w_rptr` directly, with no logic between stages.
- **Gray decode.** Combinational from `w_rptr`: `rbin[ASIZE]` = `g[ASIZE]`; `rbin[i]` = `rbin[i+1]` ^ `g[i]` for i = ASIZE-1 down to 0.
- **Level.**
  - `lvl` = (`wbin` − `rbin`) mod 2^(ASIZE+1), computed combinationally at ASIZE+1 bits. Pointer wrap is therefore transparent.
  - `wcount` is registered `lvl`, clamped to DEPTH when `lvl` > DEPTH.
- **Flags.** `walmost_full` and `wfull_reg` are registered from `lvl` (clamped), so they are coincident with `wcount`.
- **Combinational full.** `full_c` = (`lvl` == DEPTH). This is the same condition the write-side full logic evaluates on the same `w_rptr`.
- **Overflow.** `woverflow` sets on any cycle with (`wen` && `full_c`), i.e. a rejected write, or with `lvl` > DEPTH (corrupt pointer). It holds until `ovf_clr`. If set and clear occur in the same cycle, set wins.
- **High-water mark.** Each cycle `whwm` <= max(`whwm`, clamped `lvl`). With `hwm_clr` high, `whwm` loads the clamped `lvl` instead of 0.

## Timing
- **Reset.** All flops clear asynchronously on `wrstn` low, including every synchronizer stage. While in reset, all outputs are 0: `w_rptr`, `wcount`, `walmost_full`, `wfull_reg`, `woverflow`, `whwm`.
- **Reset mid-operation.** State is lost. After release, `w_rptr` tracks `rptr` once `SYNC_STAGES` `wclk` edges have passed, and `wcount` follows one edge later. Both pointer sides are reset together at system level.
- **Synchronizer latency.** A stable `rptr` change is visible on `w_rptr` after `SYNC_STAGES` rising `wclk` edges.
- **Level latency.** A `wbin` change is reflected in `wcount` and the flags after 1 edge. A `w_rptr` change is reflected after 1 edge, so `rptr` to `wcount` takes `SYNC_STAGES`+1 edges.
- **Detection latency.** `woverflow` rises 1 edge after the offending cycle. `whwm` updates 1 edge after `lvl`.
- **Pessimism.** Synchronized `rptr` lags the true read pointer, so the level is pessimistic (over-counts). The level never under-counts.
- **Simultaneous write and read in the same cycle.** Each pointer update is reflected independently with its own latency above. No special casing.

## Configuration
- Macro `WDOM_RPTR_HWM_EN`.
- **Defined:** the high-water-mark register and `hwm_clr` logic are present as described.
- **Undefined:** `whwm` is tied to 0, `hwm_clr` is ignored, and no HWM flops are instantiated. All other behaviour is identical.

## Test plan
All scenarios use ASIZE=4, SYNC_STAGES=2, AFULL_TH=12, `WDOM_RPTR_HWM_EN` defined.

- **Reset.** Hold `wrstn`=0 with `rptr`=5'b10110 and `wbin`=9 → all outputs 0. Release → `w_rptr`=10110 after 2 edges; after the 3rd edge `rbin`=11011, `lvl` = (9 − 27) mod 32 = 14, so `wcount`=14, `walmost_full`=1 and `whwm`=14.
- **Fill to full.** `rptr`=0, step `wbin` 0→16 one per cycle → `walmost_full` rises 1 edge after `wbin`=12, `wfull_reg` rises 1 edge after `wbin`=16, `wcount`=16.
- **Overflow.** At `wcount`=16, pulse `wen` 1 cycle → `woverflow`=1 next edge. Assert `ovf_clr` together with `wen` → stays 1. `ovf_clr` alone → 0.
- **Wrap.** `wbin`=3, `rptr`=Gray(29)=5'b10011 → `wcount` = (3 − 29) mod 32 = 6, with no flags set.
- **Corrupt pointer.** `wbin`=20, `rptr`=Gray(0) → `lvl`=20; `wcount` clamps to 16, `wfull_reg`=1, `woverflow`=1.
- **HWM clear.** Level rises to 13, then drains to 4; `hwm_clr` pulse → `whwm`=13 until the clear, then 4 one edge after the pulse.
